// File: rtl/bcd_seg_scanner.sv
// Two-digit BCD to 7-segment scanner with per-frame snapshot and inter-digit blanking.
// Latency: inputs are visible from the frame after the next capture edge. Outputs are Moore. No backpressure.
module bcd_seg_scanner #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_DIV = 50,
    parameter int LZB       = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] bcd_0,
    input  logic [3:0] bcd_1,
    output logic [6:0] seg,
    output logic [1:0] dig_sel,
    output logic       frame_tick
);

    localparam int MAX_DIV = (SCAN_DIV > BLANK_DIV) ? SCAN_DIV : BLANK_DIV;
    localparam int CW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [1:0] SHOW0  = 2'd0;
    localparam logic [1:0] BLANK0 = 2'd1;
    localparam logic [1:0] SHOW1  = 2'd2;
    localparam logic [1:0] BLANK1 = 2'd3;

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    snap_0_q, snap_0_d;
    logic [3:0]    snap_1_q, snap_1_d;
    logic [CW-1:0] phase_last;

    function automatic logic [6:0] enc(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        snap_0_d   = snap_0_q;
        snap_1_d   = snap_1_q;
        phase_last = (state_q == SHOW0 || state_q == SHOW1) ? SCAN_LAST : BLANK_LAST;
        if (cnt_q == phase_last) begin
            cnt_d   = '0;
            state_d = state_q + 2'd1;
            // Both digits are taken from the same edge so a frame never shows a torn value.
            if (state_q == BLANK1) begin
                snap_0_d = bcd_0;
                snap_1_d = bcd_1;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= BLANK1;
            cnt_q    <= '0;
            snap_0_q <= 4'd0;
            snap_1_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            snap_0_q <= snap_0_d;
            snap_1_q <= snap_1_d;
        end
    end

    always_comb begin
        seg        = 7'h00;
        dig_sel    = 2'b00;
        frame_tick = 1'b0;
        case (state_q)
            SHOW0: begin
                seg        = enc(snap_0_q);
                dig_sel    = 2'b01;
                frame_tick = (cnt_q == '0);
            end
            SHOW1: begin
                if (!(LZB != 0 && snap_1_q == 4'd0)) begin
                    seg     = enc(snap_1_q);
                    dig_sel = 2'b10;
                end
            end
            default: begin
                seg     = 7'h00;
                dig_sel = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Directed bench for bcd_seg_scanner with SCAN_DIV=4, BLANK_DIV=2 (12-cycle frame), LZB=1 and LZB=0 instances.
module tb_bcd_seg_scanner;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] bcd_0, bcd_1;
    logic [6:0] seg, seg_n;
    logic [1:0] sel, sel_n;
    logic       tick, tick_n;

    int n_chk  = 0;
    int n_pass = 0;
    int ph     = 0;

    always #5 CLK = ~CLK;

    bcd_seg_scanner #(.SCAN_DIV(4), .BLANK_DIV(2), .LZB(1)) dut (
        .CLK(CLK), .RST(RST), .bcd_0(bcd_0), .bcd_1(bcd_1),
        .seg(seg), .dig_sel(sel), .frame_tick(tick)
    );

    bcd_seg_scanner #(.SCAN_DIV(4), .BLANK_DIV(2), .LZB(0)) dut_nlz (
        .CLK(CLK), .RST(RST), .bcd_0(bcd_0), .bcd_1(bcd_1),
        .seg(seg_n), .dig_sel(sel_n), .frame_tick(tick_n)
    );

    function automatic logic [6:0] enc_ref(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
        ph = (ph + 1) % 12;
    endtask

    // Timing after release with digits 4/7: 2 dark, 4 x 07, 2 dark, 4 x 66, repeating.
    task automatic check_release_frames(input string tag, input int ncyc);
        logic [6:0] e_seg;
        logic [1:0] e_sel;
        logic       e_tick;
        for (int i = 0; i < ncyc; i++) begin
            e_seg = 7'h00; e_sel = 2'b00; e_tick = (ph == 2);
            if (ph inside {[2:5]})       begin e_seg = 7'h07; e_sel = 2'b01; end
            else if (ph inside {[8:11]}) begin e_seg = 7'h66; e_sel = 2'b10; end
            n_chk++; if (seg !== e_seg)   $display("FAIL %s_seg ph=%0d got %h exp %h", tag, ph, seg, e_seg); else n_pass++;
            n_chk++; if (sel !== e_sel)   $display("FAIL %s_sel ph=%0d got %b exp %b", tag, ph, sel, e_sel); else n_pass++;
            n_chk++; if (tick !== e_tick) $display("FAIL %s_tick ph=%0d got %b exp %b", tag, ph, tick, e_tick); else n_pass++;
            n_chk++; if (seg_n !== e_seg) $display("FAIL %s_nlz_seg ph=%0d got %h exp %h", tag, ph, seg_n, e_seg); else n_pass++;
            step();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; bcd_1 = 4'd4; bcd_0 = 4'd7;
        #3;
        n_chk++; if (seg !== 7'h00 || sel !== 2'b00 || tick !== 1'b0)
            $display("FAIL reset_async got seg=%h sel=%b tick=%b exp 00/00/0", seg, sel, tick); else n_pass++;
        repeat (3) @(posedge CLK);
        #1;
        n_chk++; if (seg !== 7'h00 || sel !== 2'b00 || tick !== 1'b0)
            $display("FAIL reset_held got seg=%h sel=%b tick=%b exp 00/00/0", seg, sel, tick); else n_pass++;
        n_chk++; if (seg_n !== 7'h00 || sel_n !== 2'b00 || tick_n !== 1'b0)
            $display("FAIL reset_held_nlz got seg=%h sel=%b tick=%b exp 00/00/0", seg_n, sel_n, tick_n); else n_pass++;
        RST = 1'b0;
        ph  = 0;
        check_release_frames("release", 24);
    endtask

    task automatic test_tear_free();
        logic [6:0] e_seg;
        logic [1:0] e_sel;
        for (int i = 0; i < 24; i++) begin
            if (i == 8) bcd_0 = 4'd8;
            e_seg = 7'h00; e_sel = 2'b00;
            if (ph inside {[2:5]})       begin e_seg = (i < 8) ? 7'h07 : 7'h7F; e_sel = 2'b01; end
            else if (ph inside {[8:11]}) begin e_seg = 7'h66; e_sel = 2'b10; end
            n_chk++; if (seg !== e_seg) $display("FAIL tear_seg i=%0d got %h exp %h", i, seg, e_seg); else n_pass++;
            n_chk++; if (sel !== e_sel) $display("FAIL tear_sel i=%0d got %b exp %b", i, sel, e_sel); else n_pass++;
            step();
        end
    endtask

    task automatic test_lzb();
        logic [6:0] e_seg, e_seg_n;
        logic [1:0] e_sel, e_sel_n;
        bcd_1 = 4'd0; bcd_0 = 4'd5;
        for (int i = 0; i < 12; i++) begin
            e_seg = 7'h00; e_sel = 2'b00; e_seg_n = 7'h00; e_sel_n = 2'b00;
            if (ph inside {[2:5]}) begin
                e_seg = 7'h6D; e_sel = 2'b01; e_seg_n = 7'h6D; e_sel_n = 2'b01;
            end else if (ph inside {[8:11]}) begin
                e_seg_n = 7'h3F; e_sel_n = 2'b10;
            end
            n_chk++; if (seg !== e_seg)     $display("FAIL lzb1_seg ph=%0d got %h exp %h", ph, seg, e_seg); else n_pass++;
            n_chk++; if (sel !== e_sel)     $display("FAIL lzb1_sel ph=%0d got %b exp %b", ph, sel, e_sel); else n_pass++;
            n_chk++; if (seg_n !== e_seg_n) $display("FAIL lzb0_seg ph=%0d got %h exp %h", ph, seg_n, e_seg_n); else n_pass++;
            n_chk++; if (sel_n !== e_sel_n) $display("FAIL lzb0_sel ph=%0d got %b exp %b", ph, sel_n, e_sel_n); else n_pass++;
            step();
        end
    endtask

    task automatic test_invalid();
        logic [6:0] e_seg;
        logic [1:0] e_sel;
        bcd_0 = 4'd12; bcd_1 = 4'd15;
        for (int i = 0; i < 12; i++) begin
            e_seg = 7'h00; e_sel = 2'b00;
            if (ph inside {[2:5]})       begin e_seg = 7'h40; e_sel = 2'b01; end
            else if (ph inside {[8:11]}) begin e_seg = 7'h40; e_sel = 2'b10; end
            n_chk++; if (seg !== e_seg)   $display("FAIL invalid_seg ph=%0d got %h exp %h", ph, seg, e_seg); else n_pass++;
            n_chk++; if (sel !== e_sel)   $display("FAIL invalid_sel ph=%0d got %b exp %b", ph, sel, e_sel); else n_pass++;
            n_chk++; if (seg_n !== e_seg) $display("FAIL invalid_nlz_seg ph=%0d got %h exp %h", ph, seg_n, e_seg); else n_pass++;
            step();
        end
    endtask

    task automatic test_async_reset();
        bcd_1 = 4'd4; bcd_0 = 4'd7;
        while (ph != 9) step();
        n_chk++; if (seg !== 7'h66 || sel !== 2'b10)
            $display("FAIL arst_pre got seg=%h sel=%b exp 66/10", seg, sel); else n_pass++;
        #2;
        RST = 1'b1;
        #1;
        n_chk++; if (seg !== 7'h00 || sel !== 2'b00 || tick !== 1'b0)
            $display("FAIL arst_dark got seg=%h sel=%b tick=%b exp 00/00/0", seg, sel, tick); else n_pass++;
        n_chk++; if (seg_n !== 7'h00 || sel_n !== 2'b00)
            $display("FAIL arst_dark_nlz got seg=%h sel=%b exp 00/00", seg_n, sel_n); else n_pass++;
        @(posedge CLK);
        #1;
        n_chk++; if (seg !== 7'h00 || sel !== 2'b00)
            $display("FAIL arst_held got seg=%h sel=%b exp 00/00", seg, sel); else n_pass++;
        RST = 1'b0;
        ph  = 0;
        check_release_frames("arst_release", 12);
    endtask

    task automatic test_sweep();
        int t, u, ticks, ticks_n;
        logic [6:0] e_seg, e_seg_n;
        logic [1:0] e_sel, e_sel_n;
        for (int v = 0; v < 100; v++) begin
            t = v / 10; u = v % 10;
            bcd_1 = 4'(t); bcd_0 = 4'(u);
            ticks = 0; ticks_n = 0;
            for (int i = 0; i < 12; i++) begin
                e_seg = 7'h00; e_sel = 2'b00; e_seg_n = 7'h00; e_sel_n = 2'b00;
                if (ph inside {[2:5]}) begin
                    e_seg = enc_ref(u); e_sel = 2'b01; e_seg_n = enc_ref(u); e_sel_n = 2'b01;
                end else if (ph inside {[8:11]}) begin
                    e_seg_n = enc_ref(t); e_sel_n = 2'b10;
                    if (t != 0) begin e_seg = enc_ref(t); e_sel = 2'b10; end
                end
                n_chk++; if (seg !== e_seg)     $display("FAIL sweep_seg v=%0d ph=%0d got %h exp %h", v, ph, seg, e_seg); else n_pass++;
                n_chk++; if (sel !== e_sel)     $display("FAIL sweep_sel v=%0d ph=%0d got %b exp %b", v, ph, sel, e_sel); else n_pass++;
                n_chk++; if (seg_n !== e_seg_n) $display("FAIL sweep_nlz_seg v=%0d ph=%0d got %h exp %h", v, ph, seg_n, e_seg_n); else n_pass++;
                n_chk++; if (sel_n !== e_sel_n) $display("FAIL sweep_nlz_sel v=%0d ph=%0d got %b exp %b", v, ph, sel_n, e_sel_n); else n_pass++;
                n_chk++; if (sel === 2'b11 || sel_n === 2'b11)
                    $display("FAIL sweep_onehot v=%0d ph=%0d got %b/%b exp not 11", v, ph, sel, sel_n); else n_pass++;
                if (tick === 1'b1)   ticks++;
                if (tick_n === 1'b1) ticks_n++;
                step();
            end
            n_chk++; if (ticks != 1 || ticks_n != 1)
                $display("FAIL sweep_ticks v=%0d got %0d/%0d exp 1/1", v, ticks, ticks_n); else n_pass++;
        end
    endtask

    initial begin
        RST = 1'b1; bcd_0 = 4'd0; bcd_1 = 4'd0;
        test_reset();
        test_tear_free();
        test_lzb();
        test_invalid();
        test_async_reset();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
